// File: rtl/bp_l15_response_encoder.sv
// Matches OpenPiton L1.5 return packets against in-order request metadata and
// emits BlackParrot memory responses. Optional interrupt pulses: BP_L15_ENC_INT_EN.
module bp_l15_response_encoder #(
   parameter int PENDING_DEPTH = 4,
   parameter int ADDR_WIDTH    = 40
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  req_v_i,
   output logic                  req_ready_o,
   input  logic                  req_store_i,
   input  logic [1:0]            req_size_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  l15_transducer_val,
   input  logic [3:0]            l15_transducer_returntype,
   input  logic [63:0]           l15_transducer_data_0,
   input  logic [63:0]           l15_transducer_data_1,
   output logic                  transducer_l15_req_ack,
   output logic                  mem_resp_v_o,
   input  logic                  mem_resp_ready_i,
   output logic                  mem_resp_store_o,
   output logic [1:0]            mem_resp_size_o,
   output logic [ADDR_WIDTH-1:0] mem_resp_addr_o,
   output logic [63:0]           mem_resp_data_o,
   output logic                  irq_o,
   output logic                  err_o
);

   // Handshake: a return packet is consumed in the cycle where
   // l15_transducer_val && transducer_l15_req_ack; a response transfers where
   // mem_resp_v_o && mem_resp_ready_i; a request is pushed where
   // req_v_i && req_ready_o. Responses stay stable while valid and not ready.

   localparam logic [3:0] LOAD_RET = 4'b0000;
   localparam logic [3:0] ST_ACK   = 4'b0100;
   localparam int         PTR_W    = $clog2(PENDING_DEPTH);
   localparam int         CNT_W    = PTR_W + 1;

   typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

   out_state_e state_q, state_d;

   logic                  pend_store [PENDING_DEPTH];
   logic [1:0]            pend_size  [PENDING_DEPTH];
   logic [ADDR_WIDTH-1:0] pend_addr  [PENDING_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             fifo_full, fifo_empty;
   logic             push, pop;

   logic                  head_store;
   logic [1:0]            head_size;
   logic [ADDR_WIDTH-1:0] head_addr;

   logic is_load_ret, is_st_ack, is_mem_ret;
   logic can_take, ack, drain, load_resp, mismatch, err_q;

   logic [63:0] word, le_word, shifted, mask, load_data;
   logic [5:0]  shamt;

   logic                  resp_store_q;
   logic [1:0]            resp_size_q;
   logic [ADDR_WIDTH-1:0] resp_addr_q;
   logic [63:0]           resp_data_q;

   assign fifo_full  = (count_q == CNT_W'(PENDING_DEPTH));
   assign fifo_empty = (count_q == '0);

   assign is_load_ret = (l15_transducer_returntype == LOAD_RET);
   assign is_st_ack   = (l15_transducer_returntype == ST_ACK);
   assign is_mem_ret  = is_load_ret | is_st_ack;

   // Only memory returns need space in the output register; everything else
   // is consumed unconditionally.
   assign can_take = is_mem_ret ? ((state_q == OUT_EMPTY) | mem_resp_ready_i) : 1'b1;
   assign ack      = reset_n_i & l15_transducer_val & can_take;

   assign push      = req_v_i & ~fifo_full;
   assign pop       = ack & is_mem_ret & ~fifo_empty;
   assign load_resp = pop;
   assign drain     = (state_q == OUT_FULL) & mem_resp_ready_i;

   assign head_store = pend_store[rd_ptr_q];
   assign head_size  = pend_size[rd_ptr_q];
   assign head_addr  = pend_addr[rd_ptr_q];
   assign mismatch   = (is_load_ret & head_store) | (is_st_ack & ~head_store);

   // Pending metadata storage; contents are qualified by count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pend_store[wr_ptr_q] <= req_store_i;
         pend_size[wr_ptr_q]  <= req_size_i;
         pend_addr[wr_ptr_q]  <= req_addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Big-endian line half to little-endian, then align to the request offset.
   always_comb begin
      word    = head_addr[3] ? l15_transducer_data_1 : l15_transducer_data_0;
      le_word = '0;
      for (int i = 0; i < 8; i++) begin
         le_word[i*8 +: 8] = word[(7-i)*8 +: 8];
      end
      shamt   = {head_addr[2:0], 3'b000};
      shifted = le_word >> shamt;
      case (head_size)
         2'd0:    mask = 64'h0000_0000_0000_00ff;
         2'd1:    mask = 64'h0000_0000_0000_ffff;
         2'd2:    mask = 64'h0000_0000_ffff_ffff;
         default: mask = 64'hffff_ffff_ffff_ffff;
      endcase
      load_data = shifted & mask;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: if (load_resp) state_d = OUT_FULL;
         OUT_FULL: begin
            if (load_resp)  state_d = OUT_FULL;
            else if (drain) state_d = OUT_EMPTY;
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= OUT_EMPTY;
      else            state_q <= state_d;
   end

   // Response type always follows the request, even when the return disagrees.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         resp_store_q <= 1'b0;
         resp_size_q  <= '0;
         resp_addr_q  <= '0;
         resp_data_q  <= '0;
      end else if (load_resp) begin
         resp_store_q <= head_store;
         resp_size_q  <= head_size;
         resp_addr_q  <= head_addr;
         resp_data_q  <= head_store ? 64'd0 : load_data;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) err_q <= 1'b0;
      else if ((pop & mismatch) | (ack & is_mem_ret & fifo_empty)) err_q <= 1'b1;
   end

`ifdef BP_L15_ENC_INT_EN
   localparam logic [3:0] INT_RET = 4'b0111;
   logic irq_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) irq_q <= 1'b0;
      else            irq_q <= ack & (l15_transducer_returntype == INT_RET);
   end

   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

   assign req_ready_o            = ~fifo_full;
   assign transducer_l15_req_ack = ack;
   assign mem_resp_v_o           = (state_q == OUT_FULL);
   assign mem_resp_store_o       = resp_store_q;
   assign mem_resp_size_o        = resp_size_q;
   assign mem_resp_addr_o        = resp_addr_q;
   assign mem_resp_data_o        = resp_data_q;
   assign err_o                  = err_q;

endmodule

// File: tb/tb_bp_l15_response_encoder.sv
// Directed bench for bp_l15_response_encoder with a byte-level reference model
// checked every cycle; honours BP_L15_ENC_INT_EN.
module tb_bp_l15_response_encoder;
   localparam int DEPTH = 4;
   localparam int AW    = 40;
   localparam logic [3:0] RT_LOAD = 4'h0;
   localparam logic [3:0] RT_ST   = 4'h4;
   localparam logic [3:0] RT_INT  = 4'h7;
   localparam logic [3:0] RT_UNK  = 4'hf;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          req_v_i, req_ready_o, req_store_i;
   logic [1:0]    req_size_i;
   logic [AW-1:0] req_addr_i;
   logic          l15_transducer_val;
   logic [3:0]    l15_transducer_returntype;
   logic [63:0]   l15_transducer_data_0, l15_transducer_data_1;
   logic          transducer_l15_req_ack;
   logic          mem_resp_v_o, mem_resp_ready_i, mem_resp_store_o;
   logic [1:0]    mem_resp_size_o;
   logic [AW-1:0] mem_resp_addr_o;
   logic [63:0]   mem_resp_data_o;
   logic          irq_o, err_o;

   bp_l15_response_encoder #(.PENDING_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
      .req_size_i(req_size_i), .req_addr_i(req_addr_i),
      .l15_transducer_val(l15_transducer_val),
      .l15_transducer_returntype(l15_transducer_returntype),
      .l15_transducer_data_0(l15_transducer_data_0),
      .l15_transducer_data_1(l15_transducer_data_1),
      .transducer_l15_req_ack(transducer_l15_req_ack),
      .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i),
      .mem_resp_store_o(mem_resp_store_o), .mem_resp_size_o(mem_resp_size_o),
      .mem_resp_addr_o(mem_resp_addr_o), .mem_resp_data_o(mem_resp_data_o),
      .irq_o(irq_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic          store;
      logic [1:0]    size;
      logic [AW-1:0] addr;
   } req_t;

   req_t          pend_q[$];
   req_t          m_head;
   logic          m_v, m_store, m_err, m_irq;
   logic [1:0]    m_size;
   logic [AW-1:0] m_addr;
   logic [63:0]   m_data;
   logic          e_ready, e_ack, e_mem_ret, e_can_take, m_nv, m_push;

   // Line bytes in address order; bytes past the end of the 8-byte word read as zero.
   function automatic logic [63:0] exp_data(input logic [63:0] d0, input logic [63:0] d1,
                                            input logic [AW-1:0] a, input logic [1:0] sz);
      logic [7:0]  line [16];
      logic [63:0] r;
      int          base, off;
      for (int k = 0; k < 8; k++) begin
         line[k]     = d0[63-8*k -: 8];
         line[8 + k] = d1[63-8*k -: 8];
      end
      base = a[3] ? 8 : 0;
      off  = int'(a[2:0]);
      r    = 64'd0;
      for (int j = 0; j < (1 << sz); j++) begin
         if (off + j < 8) r[8*j +: 8] = line[base + off + j];
      end
      return r;
   endfunction

   always @(negedge clk_i) begin
      if (!reset_n_i) begin
         pend_q.delete();
         m_v = 0; m_store = 0; m_size = 0; m_addr = 0; m_data = 0; m_err = 0; m_irq = 0;
      end
      e_ready    = (pend_q.size() < DEPTH);
      e_mem_ret  = (l15_transducer_returntype == RT_LOAD) || (l15_transducer_returntype == RT_ST);
      e_can_take = e_mem_ret ? (!m_v || mem_resp_ready_i) : 1'b1;
      e_ack      = reset_n_i && l15_transducer_val && e_can_take;

      check("req_ready", req_ready_o, e_ready);
      check("req_ack", transducer_l15_req_ack, e_ack);
      check("resp_v", mem_resp_v_o, m_v);
      check("irq", irq_o, m_irq);
      check("err", err_o, m_err);
      if (m_v) begin
         check("resp_store", mem_resp_store_o, m_store);
         check("resp_size", mem_resp_size_o, m_size);
         check("resp_addr", mem_resp_addr_o, m_addr);
         check("resp_data", mem_resp_data_o, m_data);
      end

      if (reset_n_i) begin
         m_push = req_v_i && e_ready;
         m_nv   = m_v && !mem_resp_ready_i;
         m_irq  = 0;
         if (e_ack && e_mem_ret) begin
            if (pend_q.size() > 0) begin
               m_head = pend_q.pop_front();
               if (m_head.store != (l15_transducer_returntype == RT_ST)) m_err = 1;
               m_store = m_head.store;
               m_size  = m_head.size;
               m_addr  = m_head.addr;
               m_data  = m_head.store ? 64'd0 :
                         exp_data(l15_transducer_data_0, l15_transducer_data_1,
                                  m_head.addr, m_head.size);
               m_nv    = 1;
            end else begin
               m_err = 1;
            end
         end
`ifdef BP_L15_ENC_INT_EN
         if (e_ack && l15_transducer_returntype == RT_INT) m_irq = 1;
`endif
         if (m_push) pend_q.push_back('{store: req_store_i, size: req_size_i, addr: req_addr_i});
         m_v = m_nv;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic store, input logic [1:0] size, input logic [AW-1:0] addr);
      req_v_i = 1; req_store_i = store; req_size_i = size; req_addr_i = addr;
      tick();
      req_v_i = 0;
   endtask

   // Holds the packet until acked (bounded), returns one cycle after the ack cycle.
   task automatic ret(input logic [3:0] t, input logic [63:0] d0, input logic [63:0] d1);
      int n;
      n = 0;
      l15_transducer_val = 1; l15_transducer_returntype = t;
      l15_transducer_data_0 = d0; l15_transducer_data_1 = d1;
      #1;
      while (!transducer_l15_req_ack && n < 20) begin
         @(posedge clk_i);
         #2;
         n++;
      end
      check("ret_ack_within_budget", transducer_l15_req_ack, 1'b1);
      @(posedge clk_i);
      #1;
      l15_transducer_val = 0;
   endtask

   logic exp_irq;

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef BP_L15_ENC_INT_EN
      exp_irq = 1;
`else
      exp_irq = 0;
`endif
      reset_n_i = 0; req_v_i = 0; req_store_i = 0; req_size_i = 0; req_addr_i = 0;
      l15_transducer_val = 1; l15_transducer_returntype = RT_LOAD;
      l15_transducer_data_0 = 0; l15_transducer_data_1 = 0; mem_resp_ready_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ack", transducer_l15_req_ack, 0);
      check("rst_ready", req_ready_o, 1);
      check("rst_v", mem_resp_v_o, 0);
      check("rst_data", mem_resp_data_o, 0);
      check("rst_addr", mem_resp_addr_o, 0);
      check("rst_err", err_o, 0);
      check("rst_irq", irq_o, 0);
      l15_transducer_val = 0;
      reset_n_i = 1;
      tick();

      // Basic load: size 4B at 0x0C from the upper line half.
      push(0, 2, 40'h00_0000_000C);
      ret(RT_LOAD, 64'hdead_beef_cafe_f00d, 64'h0011_2233_4455_6677);
      check("t1_v", mem_resp_v_o, 1);
      check("t1_data", mem_resp_data_o, 64'h0000_0000_7766_5544);
      check("t1_store", mem_resp_store_o, 0);
      check("t1_addr", mem_resp_addr_o, 40'h0C);
      push(0, 0, 40'h05);
      ret(RT_LOAD, 64'h0011_2233_4455_6677, 64'h0);
      check("t1b_data", mem_resp_data_o, 64'h55);
      push(0, 3, 40'h08);
      ret(RT_LOAD, 64'h0, 64'h8899_aabb_ccdd_eeff);
      check("t1c_data", mem_resp_data_o, 64'hffee_ddcc_bbaa_9988);
      push(0, 1, 40'h07);
      ret(RT_LOAD, 64'h0011_2233_4455_6677, 64'h0);
      check("t1d_data", mem_resp_data_o, 64'h77);
      tick();

      // Stores under back-pressure.
      mem_resp_ready_i = 0;
      push(1, 3, 40'h40);
      push(1, 1, 40'h48);
      ret(RT_ST, 64'h1111, 64'h2222);
      l15_transducer_val = 1; l15_transducer_returntype = RT_ST;
      repeat (3) begin
         #1;
         check("t2_hold_ack", transducer_l15_req_ack, 0);
         check("t2_hold_addr", mem_resp_addr_o, 40'h40);
         @(posedge clk_i);
         #1;
      end
      mem_resp_ready_i = 1;
      #1;
      check("t2_drain_ack", transducer_l15_req_ack, 1);
      @(posedge clk_i);
      #1;
      l15_transducer_val = 0;
      check("t2_second_addr", mem_resp_addr_o, 40'h48);
      check("t2_second_data", mem_resp_data_o, 0);
      check("t2_second_store", mem_resp_store_o, 1);
      tick();

      // Fill the FIFO; the fifth request must be ignored.
      for (int i = 0; i < 4; i++) push(0, 3, AW'(40'h100 + 8 * i));
      check("t3_full", req_ready_o, 0);
      push(0, 3, 40'h999);
      check("t3_still_full", req_ready_o, 0);
      ret(RT_LOAD, 64'h0123_4567_89ab_cdef, 64'h0);
      check("t3_ready_back", req_ready_o, 1);
      check("t3_data", mem_resp_data_o, 64'hefcd_ab89_6745_2301);
      check("t3_addr", mem_resp_addr_o, 40'h100);
      ret(RT_LOAD, 64'h0, 64'h0102_0304_0506_0708);
      ret(RT_LOAD, 64'h1112_1314_1516_1718, 64'h0);
      ret(RT_LOAD, 64'h0, 64'h2122_2324_2526_2728);
      tick();

      // Memory return with nothing outstanding.
      check("t4_err_before", err_o, 0);
      ret(RT_ST, 64'h0, 64'h0);
      check("t4_no_v", mem_resp_v_o, 0);
      check("t4_err", err_o, 1);
      repeat (3) tick();
      check("t4_err_sticky", err_o, 1);

      // Interrupts and unknown types leave the FIFO alone.
      push(0, 3, 40'h200);
      ret(RT_INT, 64'h0, 64'h0);
      check("t5_irq", irq_o, exp_irq);
      tick();
      check("t5_irq_low", irq_o, 0);
      l15_transducer_val = 1; l15_transducer_returntype = RT_INT;
      #1;
      check("t5_b2b_ack0", transducer_l15_req_ack, 1);
      @(posedge clk_i);
      #1;
      check("t5_b2b_irq0", irq_o, exp_irq);
      @(posedge clk_i);
      #1;
      l15_transducer_val = 0;
      check("t5_b2b_irq1", irq_o, exp_irq);
      tick();
      ret(RT_UNK, 64'h0, 64'h0);
      check("t5_unk_no_v", mem_resp_v_o, 0);
      ret(RT_LOAD, 64'h0, 64'hf0e1_d2c3_b4a5_9687);
      check("t5_fifo_kept", mem_resp_addr_o, 40'h200);
      tick();

      // Asynchronous reset with two pending and the output occupied.
      mem_resp_ready_i = 0;
      push(0, 3, 40'h300);
      push(0, 3, 40'h308);
      push(0, 3, 40'h310);
      ret(RT_LOAD, 64'h5555, 64'h0);
      l15_transducer_val = 1; l15_transducer_returntype = RT_LOAD;
      reset_n_i = 0;
      #1;
      check("t6_rst_ack", transducer_l15_req_ack, 0);
      check("t6_rst_ready", req_ready_o, 1);
      check("t6_rst_v", mem_resp_v_o, 0);
      check("t6_rst_addr", mem_resp_addr_o, 0);
      check("t6_rst_data", mem_resp_data_o, 0);
      check("t6_rst_err", err_o, 0);
      tick();
      l15_transducer_val = 0;
      tick();
      reset_n_i = 1;
      mem_resp_ready_i = 1;
      tick();
      check("t6_post_ready", req_ready_o, 1);
      ret(RT_LOAD, 64'h0, 64'h0);
      check("t6_post_err", err_o, 1);
      check("t6_post_no_v", mem_resp_v_o, 0);

      // Return type disagrees with the outstanding request.
      reset_n_i = 0;
      tick();
      reset_n_i = 1;
      tick();
      push(1, 2, 40'h404);
      ret(RT_LOAD, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff);
      check("t7_v", mem_resp_v_o, 1);
      check("t7_store", mem_resp_store_o, 1);
      check("t7_data", mem_resp_data_o, 0);
      check("t7_err", err_o, 1);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
